switch_debounce_sync: RTL and testbench

Front-end input stage that conditions the 16 board slide switches before they reach the pipelined MIPS CPU top level. It synchronises and debounces each switch, then forms two 8-bit operands: low byte = i0..i7, high byte = i8..i15. These operands are the GCD inputs that the CPU program stores into Mem[4] and Mem[5]. A valid/ack handshake tells the CPU when a new, stable operand pair is ready.

---
 rtl/cpu_io_pkg.sv | 14 +
 rtl/debounce_bit.sv | 51 +++++
 rtl/switch_debounce_sync.sv | 119 +++++++++++
 tb/tb_switch_debounce_sync.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the switch front end feeding the MIPS CPU top:
// snapshot FSM states, operand width and debounce lengths for sim/board.
package cpu_io_pkg;

    typedef enum logic [0:0] {
        SNAP_IDLE = 1'b0,
        SNAP_PEND = 1'b1
    } snap_state_e;

    localparam int OPERAND_W             = 8;
    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 500000;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: multi-flop synchroniser, debounce counter and the
// accepted (stable) level. flip is high in the cycle before stable toggles,
// so the parent can register a change pulse that lines up with the toggle.
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic flip
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign stable = stable_r;
    assign flip   = (sync_s != stable_r) && (cnt_r == LAST_CNT);

    // Shift the asynchronous level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (sync_s == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == LAST_CNT) begin
            stable_r <= sync_s;
            cnt_r    <= '0;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/switch_debounce_sync.sv
// Switch conditioning stage: per-bit synchronise + debounce, a single change
// pulse, and a two-operand snapshot handed to the CPU with valid/ack.
module switch_debounce_sync
    import cpu_io_pkg::*;
#(
    parameter int WIDTH           = 2 * OPERAND_W,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sw_raw,
    output logic [WIDTH-1:0]   sw_stable,
    output logic               sw_changed,
    output logic [WIDTH/2-1:0] op_a,
    output logic [WIDTH/2-1:0] op_b,
    output logic               op_valid,
    input  logic               op_ack,
    output logic               overrun
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] flip_s;
    logic [WIDTH-1:0] stable_next_s;
    logic             any_flip_s;

    snap_state_e      state_r;
    logic             sw_changed_r;
    logic [HALF-1:0]  op_a_r;
    logic [HALF-1:0]  op_b_r;
    logic             op_valid_r;
    logic             overrun_r;

    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_raw[n]),
            .stable(sw_stable[n]),
            .flip  (flip_s[n])
        );
    end

    // The value sw_stable takes on the coming edge, so a capture lands with it.
    assign stable_next_s = sw_stable ^ flip_s;
    assign any_flip_s    = |flip_s;

    assign sw_changed = sw_changed_r;
    assign op_a       = op_a_r;
    assign op_b       = op_b_r;
    assign op_valid   = op_valid_r;
    assign overrun    = overrun_r;

    // One change pulse per toggle edge, however many bits toggle together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_changed_r <= 1'b0;
        end else begin
            sw_changed_r <= any_flip_s;
        end
    end

    // Snapshot handshake: capture on change, hold until ack, flag lost snapshots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= SNAP_IDLE;
            op_a_r     <= '0;
            op_b_r     <= '0;
            op_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            case (state_r)
                SNAP_IDLE: begin
                    if (any_flip_s) begin
                        op_a_r     <= stable_next_s[HALF-1:0];
                        op_b_r     <= stable_next_s[WIDTH-1:HALF];
                        op_valid_r <= 1'b1;
                        state_r    <= SNAP_PEND;
                    end else begin
                        state_r    <= SNAP_IDLE;
                    end
                end
                SNAP_PEND: begin
                    if (any_flip_s) begin
                        // A fresh value replaces the pending one; it is only
                        // lost if the CPU did not take it in this same cycle.
                        op_a_r     <= stable_next_s[HALF-1:0];
                        op_b_r     <= stable_next_s[WIDTH-1:HALF];
                        op_valid_r <= 1'b1;
                        if (!op_ack) begin
                            overrun_r <= 1'b1;
                        end else begin
                            overrun_r <= overrun_r;
                        end
                        state_r    <= SNAP_PEND;
                    end else if (op_ack) begin
                        op_valid_r <= 1'b0;
                        overrun_r  <= 1'b0;
                        state_r    <= SNAP_IDLE;
                    end else begin
                        state_r    <= SNAP_PEND;
                    end
                end
                default: begin
                    op_valid_r <= 1'b0;
                    overrun_r  <= 1'b0;
                    state_r    <= SNAP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: a vector table for the main handshake flow,
// hand-written sequences for glitch, ack/change collision and async reset,
// and a scoreboard of expected change events checked at each sw_changed pulse.
module tb_switch_debounce_sync;

    logic        clk;
    logic        rst;
    logic [15:0] sw_raw;
    logic [15:0] sw_stable;
    logic        sw_changed;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_valid;
    logic        op_ack;
    logic        overrun;

    int checks    = 0;
    int errors    = 0;
    int cycle_cnt = 0;

    typedef struct {
        int          cyc;
        logic [15:0] st;
        logic        v;
        logic        o;
    } sb_t;

    typedef struct {
        logic [15:0] raw;
        logic        ack;
        int          hold;
        logic        push;
        logic        fv;
        logic        fo;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        ev;
        logic        eo;
    } vec_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vecs[6];

    switch_debounce_sync dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_changed(sw_changed),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .op_ack    (op_ack),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A raw change driven now (after edge c) must show up at edge c+6.
    task automatic push_exp(input logic [15:0] st, input logic v, input logic o);
        sb_t e;
        e.cyc = cycle_cnt + 6;
        e.st  = st;
        e.v   = v;
        e.o   = o;
        sb.push_back(e);
    endtask

    task automatic chk_outs(input string nm, input logic [15:0] st, input logic [7:0] a,
                            input logic [7:0] b, input logic v, input logic o);
        chk({nm, "_stable"},  32'(sw_stable), 32'(st));
        chk({nm, "_op_a"},    32'(op_a),      32'(a));
        chk({nm, "_op_b"},    32'(op_b),      32'(b));
        chk({nm, "_valid"},   32'(op_valid),  32'(v));
        chk({nm, "_overrun"}, 32'(overrun),   32'(o));
    endtask

    // Scoreboard: every change pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst && sw_changed) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_pulse: got sw_changed=1 stable=%h expected no pulse (cycle %0d)",
                         sw_stable, cycle_cnt);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_cycle",   32'(cycle_cnt), 32'(mon_e.cyc));
                chk("sb_stable",  32'(sw_stable), 32'(mon_e.st));
                chk("sb_op_a",    32'(op_a),      32'(mon_e.st[7:0]));
                chk("sb_op_b",    32'(op_b),      32'(mon_e.st[15:8]));
                chk("sb_valid",   32'(op_valid),  32'(mon_e.v));
                chk("sb_overrun", 32'(overrun),   32'(mon_e.o));
            end
        end
    end

    initial begin
        //          raw       ack   hold push fv    fo    ea     eb     ev    eo
        vecs[0] = '{16'h0204, 1'b0, 8,   1'b1, 1'b1, 1'b0, 8'h04, 8'h02, 1'b1, 1'b0};
        vecs[1] = '{16'h0204, 1'b1, 2,   1'b0, 1'b0, 1'b0, 8'h04, 8'h02, 1'b0, 1'b0};
        vecs[2] = '{16'h0204, 1'b1, 2,   1'b0, 1'b0, 1'b0, 8'h04, 8'h02, 1'b0, 1'b0};
        vecs[3] = '{16'h8001, 1'b0, 8,   1'b1, 1'b1, 1'b0, 8'h01, 8'h80, 1'b1, 1'b0};
        vecs[4] = '{16'h0306, 1'b0, 8,   1'b1, 1'b1, 1'b1, 8'h06, 8'h03, 1'b1, 1'b1};
        vecs[5] = '{16'h0306, 1'b1, 2,   1'b0, 1'b0, 1'b0, 8'h06, 8'h03, 1'b0, 1'b0};

        rst    = 1'b0;
        sw_raw = 16'h0000;
        op_ack = 1'b0;
        tick(3);
        chk_outs("reset", 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("reset_changed", 32'(sw_changed), 32'd0);

        rst = 1'b1;
        tick(2);

        // Table: power-up capture, ack, ack in IDLE, multi-bit change, overrun, clear.
        for (int i = 0; i < 6; i++) begin
            sw_raw = vecs[i].raw;
            op_ack = vecs[i].ack;
            if (vecs[i].push) push_exp(vecs[i].raw, vecs[i].fv, vecs[i].fo);
            tick(1);
            op_ack = 1'b0;
            tick(vecs[i].hold - 1);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].raw, vecs[i].ea, vecs[i].eb,
                     vecs[i].ev, vecs[i].eo);
            @(posedge clk);
            #1;
        end

        // Glitch of 3 cycles is rejected; 4 cycles is accepted, then it returns.
        sw_raw = 16'h0307;
        tick(3);
        sw_raw = 16'h0306;
        tick(8);
        @(negedge clk);
        chk_outs("glitch", 16'h0306, 8'h06, 8'h03, 1'b0, 1'b0);
        chk("glitch_changed", 32'(sw_changed), 32'd0);
        @(posedge clk);
        #1;
        sw_raw = 16'h0307;
        push_exp(16'h0307, 1'b1, 1'b0);
        tick(4);
        sw_raw = 16'h0306;
        push_exp(16'h0306, 1'b1, 1'b1);
        tick(10);
        @(negedge clk);
        chk_outs("pulse4", 16'h0306, 8'h06, 8'h03, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        op_ack = 1'b1;
        tick(1);
        op_ack = 1'b0;
        tick(1);

        // Change and ack on the same edge: recapture, no overrun.
        sw_raw = 16'h1122;
        push_exp(16'h1122, 1'b1, 1'b0);
        tick(8);
        sw_raw = 16'h3344;
        push_exp(16'h3344, 1'b1, 1'b0);
        tick(5);
        op_ack = 1'b1;
        tick(1);
        op_ack = 1'b0;
        @(negedge clk);
        chk_outs("collide", 16'h3344, 8'h44, 8'h33, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        op_ack = 1'b1;
        tick(1);
        op_ack = 1'b0;
        tick(1);

        // Async reset while PEND and mid-count, then a full-latency re-debounce.
        sw_raw = 16'h00FF;
        push_exp(16'h00FF, 1'b1, 1'b0);
        tick(8);
        sw_raw = 16'h5A5A;
        tick(4);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("async_rst", 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("async_rst_changed", 32'(sw_changed), 32'd0);
        tick(2);
        rst = 1'b1;
        push_exp(16'h5A5A, 1'b1, 1'b0);
        tick(10);
        @(negedge clk);
        chk_outs("post_rst", 16'h5A5A, 8'h5A, 8'h5A, 1'b1, 1'b0);

        chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
